// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// -----------------
// Round-robin arbiter that lets NUM_REQ requesters take turns writing one
// shared WIDTH-bit register. After each write the block can sit in a HOLD
// state for HOLD_CYCLES cycles before it grants again. This spaces writes
// HOLD_CYCLES+1 cycles apart under continuous demand.
//
// Ports
//   clk       : single clock, all state changes on its rising edge
//   rst       : synchronous, active-high reset (overrides everything)
//   clr       : synchronous clear of the shared register (beats a grant)
//   req       : per-requester level request, held until acked
//   wdata     : write data, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-hot, one-cycle pulse completing requester i's write
//   q         : shared register contents
//   q_valid   : q has been written since the last reset or clear
//   grant_id  : index of the most recent writer
//   busy      : high while the block is in HOLD
module reg_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  // Start with the pointer on the top requester so requester 0 is searched first.
  localparam logic [IDW-1:0] LAST_RST  = IDW'(NUM_REQ - 1);
  localparam bit             HOLD_EN   = (HOLD_CYCLES != 0);
  localparam logic [7:0]     HOLD_LOAD = HOLD_EN ? 8'(HOLD_CYCLES - 1) : 8'd0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] eff_req_s;
  logic [WIDTH-1:0]   wdata_arr_s [NUM_REQ];
  logic               pick_found_s;
  logic [IDW-1:0]     pick_idx_s;

  // Round-robin search: scan upward from last+1, wrapping at NUM_REQ.
  // Returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] eff,
                                           input logic [IDW-1:0]     last);
    logic           found;
    logic [IDW-1:0] win;
    int             idx;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found && eff[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Unpack the flat write-data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata_arr_s[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // A requester acked this cycle is masked so its still-high req is not regranted.
  always_comb begin
    eff_req_s                  = req & ~ack_q;
    {pick_found_s, pick_idx_s} = rr_pick(eff_req_s, last_q);
  end

  // Next-state and output logic for the IDLE/HOLD machine.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    ack_d      = '0;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    grant_id_d = grant_id_q;

    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          // Clear wins over a same-cycle grant. The request stays pending.
          q_d       = '0;
          q_valid_d = 1'b0;
        end else if (pick_found_s) begin
          q_d               = wdata_arr_s[pick_idx_s];
          q_valid_d         = 1'b1;
          grant_id_d        = pick_idx_s;
          last_d            = pick_idx_s;
          ack_d[pick_idx_s] = 1'b1;
          if (HOLD_EN) begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // clr affects only the register. The hold countdown runs on.
        if (clr) begin
          q_d       = '0;
          q_valid_d = 1'b0;
        end else begin
          q_d       = q_q;
        end
        if (hold_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = 8'd0;
      end
    endcase

    busy_d = (state_d == ST_HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 8'd0;
      last_q     <= LAST_RST;
      ack_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clr;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   wdata;

  // dut: HOLD_CYCLES=2, dut0: HOLD_CYCLES=0, both fed the same inputs
  logic [NR-1:0] ack_a, ack_b;
  logic [W-1:0]  q_a, q_b;
  logic          qv_a, qv_b;
  logic [1:0]    gid_a, gid_b;
  logic          busy_a, busy_b;

  reg_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .wdata(wdata),
    .ack(ack_a), .q(q_a), .q_valid(qv_a), .grant_id(gid_a), .busy(busy_a)
  );

  reg_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .wdata(wdata),
    .ack(ack_b), .q(q_b), .q_valid(qv_b), .grant_id(gid_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a cooldown count of blocked cycles per instance.
  int            hold_m [2] = '{2, 0};
  logic [W-1:0]  m_q    [2];
  logic          m_qv   [2];
  int            m_gid  [2];
  int            m_last [2];
  int            m_cool [2];
  logic [NR-1:0] m_ack  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int d);
    logic [NR-1:0] eff, nack;
    int w;
    if (rst) begin
      m_q[d] = '0; m_qv[d] = 1'b0; m_gid[d] = 0; m_last[d] = NR - 1;
      m_cool[d] = 0; m_ack[d] = '0;
    end else begin
      eff  = req & ~m_ack[d];
      nack = '0;
      if (m_cool[d] > 0) begin
        m_cool[d]--;
        if (clr) begin m_q[d] = '0; m_qv[d] = 1'b0; end
      end else if (clr) begin
        m_q[d] = '0; m_qv[d] = 1'b0;
      end else if (eff != '0) begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_last[d] + k) % NR;
          if (w < 0 && eff[i]) w = i;
        end
        m_q[d]    = wdata[w*W +: W];
        m_qv[d]   = 1'b1;
        m_gid[d]  = w;
        m_last[d] = w;
        nack[w]   = 1'b1;
        m_cool[d] = hold_m[d];
      end
      m_ack[d] = nack;
    end
  endtask

  // One clock: model follows the edge, then every output of both DUTs is compared.
  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    chk("ack_a",  32'(ack_a),  32'(m_ack[0]));
    chk("q_a",    32'(q_a),    32'(m_q[0]));
    chk("qv_a",   32'(qv_a),   32'(m_qv[0]));
    chk("gid_a",  32'(gid_a),  32'(m_gid[0]));
    chk("busy_a", 32'(busy_a), 32'(m_cool[0] > 0));
    chk("ack_b",  32'(ack_b),  32'(m_ack[1]));
    chk("q_b",    32'(q_b),    32'(m_q[1]));
    chk("qv_b",   32'(qv_b),   32'(m_qv[1]));
    chk("gid_b",  32'(gid_b),  32'(m_gid[1]));
    chk("busy_b", 32'(busy_b), 32'(m_cool[1] > 0));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; wdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_q",    32'(q_a),    32'h0);
    chk("reset_qv",   32'(qv_a),   32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    chk("reset_gid",  32'(gid_a),  32'h0);

    // single write
    wdata[7:0] = 8'hA5; req = 4'b0001;
    step();
    chk("sw_ack", 32'(ack_a), 32'h1);
    chk("sw_q",   32'(q_a),   32'hA5);
    chk("sw_qv",  32'(qv_a),  32'h1);
    chk("sw_gid", 32'(gid_a), 32'h0);
    chk("sw_busy1", 32'(busy_a), 32'h1);
    req = 4'b0000;
    step();
    chk("sw_busy2",   32'(busy_a), 32'h1);
    chk("sw_one_ack", 32'(ack_a),  32'h0);
    step();
    chk("sw_idle", 32'(busy_a), 32'h0);
    step();
    chk("sw_no_ack2", 32'(ack_a), 32'h0);

    // round-robin from reset, continuous demand
    rst = 1'b1; step(); rst = 1'b0;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i % 3 == 1) begin
        chk("rr_ack", 32'(ack_a), 32'(1 << ((i / 3) % 4)));
        chk("rr_q",   32'(q_a),   32'(8'h11 * (((i / 3) % 4) + 1)));
      end else begin
        chk("rr_gap", 32'(ack_a), 32'h0);
      end
    end

    // clr beats a same-cycle grant
    req = 4'b0000;
    step(); step(); step();
    req = 4'b0010; clr = 1'b1;
    step();
    chk("clr_ack", 32'(ack_a), 32'h0);
    chk("clr_q",   32'(q_a),   32'h0);
    chk("clr_qv",  32'(qv_a),  32'h0);
    clr = 1'b0;
    step();
    chk("clr_retry", 32'(ack_a), 32'h2);
    req = 4'b0000;
    step(); step(); step();

    // wrap and skip: last=3, then req=0101
    req = 4'b1000;
    step();
    chk("wrap_g3", 32'(gid_a), 32'h3);
    req = 4'b0000;
    step(); step(); step();
    req = 4'b0101;
    step();
    chk("wrap_0", 32'(ack_a), 32'h1);
    step(); step(); step();
    chk("skip_2", 32'(ack_a), 32'h4);
    step(); step(); step();
    chk("wrap_0b", 32'(ack_a), 32'h1);

    // back-to-back on the HOLD_CYCLES=0 instance
    req = 4'b0000;
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0011;
    step(); chk("b2b_1", 32'(ack_b), 32'h1); chk("b2b_busy1", 32'(busy_b), 32'h0);
    step(); chk("b2b_2", 32'(ack_b), 32'h2); chk("b2b_busy2", 32'(busy_b), 32'h0);
    step(); chk("b2b_3", 32'(ack_b), 32'h1); chk("b2b_busy3", 32'(busy_b), 32'h0);

    // reset one cycle after an ack
    req = 4'b0000;
    step(); step(); step();
    req = 4'b0001;
    step();
    chk("mr_ack", 32'(ack_a), 32'h1);
    req = 4'b0000; rst = 1'b1;
    step();
    chk("mr_q",    32'(q_a),    32'h0);
    chk("mr_busy", 32'(busy_a), 32'h0);
    chk("mr_ack0", 32'(ack_a),  32'h0);
    rst = 1'b0; req = 4'b1000;
    step();
    chk("mr_gid3", 32'(gid_a), 32'h3);
    chk("mr_ack3", 32'(ack_a), 32'h8);
    req = 4'b0000;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wdata = {$urandom, $urandom};
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0; req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
